irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Parametrised interrupt aggregator between peripheral interrupt sources (timers, UART rx,
//  PS/2, frameDrawn, GPIO) and the CPU. It replaces the fixed one-wire-per-source
//  int/ext_int hookup with these features:
//  - per-source synchronisation
//  - edge or level mode per source
//  - enable mask
//  - latched pending bits
//  - a priority-encoded vector
//  Registers are accessed by the MemoryUnit over a single-cycle register port.
// PARAMETERS
//  NUM_IRQ      8   number of interrupt sources (1..32)
//  SYNC_STAGES  2   synchroniser flops per source (>=1); 2 for sources from crt_clk domain
//  MODE_RESET   {NUM_IRQ{1'b1}}  reset value of MODE register (1=edge, 0=level)
//  ID_W         $clog2(NUM_IRQ) (min 1)  width of irq_id
// PORTS
//  clk       in   1        system clock
//  reset     in   1        synchronous, active-high reset
//  src       in   NUM_IRQ  raw interrupt request lines, active-high, any clock domain
//  start     in   1        register access strobe, one-cycle pulse
//  addr      in   3        register select
//  we        in   1        1=write, 0=read (qualified by start)
//  data      in   32       write data
//  q         out  32       read data, valid while done=1
//  done      out  1        access complete pulse
//  irq       out  1        CPU interrupt request: |(PENDING & ENABLE)
//  irq_id    out  ID_W     index of highest-priority active source (lowest index wins)
// BEHAVIOUR
//  - Reset: sync chains, edge-detect history, PENDING, ENABLE, q, done, irq, irq_id all 0;
//    MODE=MODE_RESET. Reset is applied on the clk edge only and wins over every other event.
//  - Sync: each src bit passes SYNC_STAGES flops giving s[i]; prev[i] <= s[i] every cycle.
//  - Set condition per bit:
//    - edge mode (MODE[i]=1): set = s[i] & ~prev[i].
//    - level mode: set = s[i].
//  - PENDING[i] next = set | (PENDING[i] & ~clr[i]); clr = W1C write mask. Set wins over
//    clear in the same cycle; a level source still high re-pends the bit on the next edge.
//  - A source held high through reset produces exactly one pending edge after release
//    (history resets to 0).
//  - irq/irq_id are registered from PENDING&ENABLE: one edge after PENDING/ENABLE update.
//    irq_id=0 when irq=0.
//  - Latency, edge mode: irq rises on the (SYNC_STAGES+2)th rising edge, counting the
//    first edge that samples src high.
//  - Register map (addr): bits >= NUM_IRQ read 0 and ignore writes.
//    0 PENDING  R / W1C
//    1 ENABLE   RW
//    2 MODE     RW
//    3 VECTOR   R: {irq, 23'b0, 8'(irq_id)}
//    4 RAW      R: s (synchronised inputs)
//    5-7        read 0, writes ignored
//  - Access: start sampled on edge k. Writes commit on edge k. done=1 and q valid for
//    exactly edge k+1 to k+2. q=0 for writes.
//  - Reads return the register value before edge k (PENDING excludes sets from the
//    same cycle).
//  - Back-to-back starts are allowed every cycle; no busy, no stall.
//  - Writing MODE changes set logic from the next cycle; PENDING is not cleared by a
//    mode change.
//  - ENABLE=0 masks irq only; PENDING still latches.
// TESTING
//  1. Reset then ENABLE=0x01; pulse src[0] for 1 cycle -> PENDING=0x01, irq=1, irq_id=0
//     on edge SYNC_STAGES+2; W1C 0x01 -> irq=0 two edges later.
//  2. ENABLE=0xFF; src[5] and src[2] rise same cycle -> irq_id=2; W1C 0x04 -> irq_id=5;
//     W1C 0x20 -> irq=0.
//  3. MODE=0xFE (src[0] level); hold src[0]=1, W1C 0x01 -> PENDING[0] reads 1 again next
//     access; drop src[0], W1C -> PENDING=0.
//  4. ENABLE=0; pulse src[3] -> irq stays 0, PENDING=0x08; write ENABLE=0x08 -> irq=1 on
//     next edge after write commit.
//  5. W1C 0x02 in same cycle as src[1] edge reaches set -> PENDING[1] remains 1.
//  6. Reset asserted mid-pending with src[4] held high -> all outputs 0 during reset;
//     after release exactly one pending for bit 4; reads of addr 5-7 return 0, done
//     pulses one cycle each.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: synchronised edge/level interrupt aggregator with W1C pending, enable mask and lowest-index-wins vector
module irq_controller #(
  parameter int NUM_IRQ = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] MODE_RESET = {NUM_IRQ{1'b1}},
  parameter int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] src,
  input  logic               start,
  input  logic [2:0]         addr,
  input  logic               we,
  input  logic [31:0]        data,
  output logic [31:0]        q,
  output logic               done,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id
);
  logic [NUM_IRQ-1:0] chain [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s, prev, pending, enable, mode, act, set, clr;
  logic [ID_W-1:0] id_n;
  logic [31:0] rd, q1;
  logic v1, wr, unused_data;
  assign s = chain[SYNC_STAGES-1];
  assign act = pending & enable;
  assign set = s & (~mode | ~prev);
  assign wr = start && we;
  assign clr = (wr && addr == 3'd0) ? data[NUM_IRQ-1:0] : '0;
  assign unused_data = ^data;
  always_comb begin
    id_n = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) id_n = act[i] ? ID_W'(i) : id_n;
  end
  always_comb rd = addr == 3'd0 ? 32'(pending) :
                   addr == 3'd1 ? 32'(enable) :
                   addr == 3'd2 ? 32'(mode) :
                   addr == 3'd3 ? {irq, 23'b0, 8'(irq_id)} :
                   addr == 3'd4 ? 32'(s) : 32'h0;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev <= '0;
      pending <= '0;
      enable <= '0;
      mode <= MODE_RESET;
      irq <= 1'b0;
      irq_id <= '0;
      v1 <= 1'b0;
      q1 <= '0;
      done <= 1'b0;
      q <= '0;
    end else begin
      chain[0] <= src;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= s;
      pending <= set | (pending & ~clr);
      enable <= (wr && addr == 3'd1) ? data[NUM_IRQ-1:0] : enable;
      mode <= (wr && addr == 3'd2) ? data[NUM_IRQ-1:0] : mode;
      irq <= |act;
      irq_id <= id_n;
      v1 <= start;
      q1 <= (start && !we) ? rd : '0;
      done <= v1;
      q <= q1;
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus randomized traffic against a behavioural model
module tb_irq_controller;
  localparam int SS = 2;
  logic clk = 0, reset = 1, start = 0, we = 0, done, irq;
  logic [7:0] src = 0;
  logic [2:0] addr = 0, irq_id;
  logic [31:0] data = 0, q;
  int checks = 0, errors = 0;

  irq_controller #(.NUM_IRQ(8), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .src(src), .start(start), .addr(addr), .we(we),
    .data(data), .q(q), .done(done), .irq(irq), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  logic [7:0] m_pend, m_en, m_mode, hist[$];
  logic m_irq, m_done, m_v1;
  logic [2:0] m_id;
  logic [31:0] m_q, m_q1;

  always @(posedge clk) begin
    logic [7:0] ms, mp, act, set, clr;
    logic [31:0] rdv;
    logic [2:0] id;
    if (reset) begin
      m_pend = 0; m_en = 0; m_mode = 8'hFF; m_irq = 0; m_id = 0;
      m_done = 0; m_v1 = 0; m_q = 0; m_q1 = 0;
      hist.delete();
    end else begin
      ms = (hist.size() >= SS) ? hist[SS-1] : 8'h0;
      mp = (hist.size() > SS) ? hist[SS] : 8'h0;
      act = m_pend & m_en;
      id = 0;
      for (int i = 7; i >= 0; i--) if (act[i]) id = 3'(i);
      case (addr)
        3'd0: rdv = {24'h0, m_pend};
        3'd1: rdv = {24'h0, m_en};
        3'd2: rdv = {24'h0, m_mode};
        3'd3: rdv = {m_irq, 23'h0, 5'h0, m_id};
        3'd4: rdv = {24'h0, ms};
        default: rdv = 0;
      endcase
      for (int i = 0; i < 8; i++) set[i] = m_mode[i] ? (ms[i] && !mp[i]) : ms[i];
      clr = (start && we && addr == 0) ? data[7:0] : 8'h0;
      m_done = m_v1; m_q = m_q1;
      m_v1 = start; m_q1 = (start && !we) ? rdv : 0;
      m_pend = set | (m_pend & ~clr);
      if (start && we && addr == 1) m_en = data[7:0];
      if (start && we && addr == 2) m_mode = data[7:0];
      m_irq = |act; m_id = id;
      hist.push_front(src);
      if (hist.size() > SS + 1) void'(hist.pop_back());
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic acc(input logic [2:0] a, input logic w, input logic [31:0] d);
    start = 1; addr = a; we = w; data = d;
    @(negedge clk);
    start = 0; we = 0; addr = 0; data = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cyc(3);
    checks++;
    if ({irq, irq_id, done, q} !== 0) begin
      errors++; $display("FAIL reset_outputs: got irq=%b id=%0d done=%b q=%h, want all 0", irq, irq_id, done, q);
    end
    reset = 0;
    acc(2, 0, 0); cyc();
    checks++;
    if (done !== 1 || q !== 32'hFF) begin
      errors++; $display("FAIL reset_mode: got done=%b q=%h, want 1 000000ff", done, q);
    end
  endtask

  task automatic test_edge_latency();
    acc(1, 1, 32'h01); cyc(2);
    src = 8'h01;
    for (int i = 1; i <= SS + 3; i++) begin
      cyc();
      if (i == 1) src = 0;
      checks++;
      if (irq !== (i >= SS + 2) || irq !== m_irq || irq_id !== 0) begin
        errors++; $display("FAIL edge_latency edge %0d: got irq=%b id=%0d, want irq=%b id=0", i, irq, irq_id, i >= SS + 2);
      end
    end
    acc(0, 0, 0); cyc();
    checks++;
    if (done !== 1 || q !== 32'h01) begin
      errors++; $display("FAIL pending_read: got done=%b q=%h, want 1 00000001", done, q);
    end
    acc(0, 1, 32'h01);
    checks++;
    if (irq !== 1) begin
      errors++; $display("FAIL w1c_hold: got irq=%b, want 1", irq);
    end
    cyc();
    checks++;
    if (irq !== 0 || done !== 1 || q !== 0) begin
      errors++; $display("FAIL w1c_clear: got irq=%b done=%b q=%h, want 0 1 0", irq, done, q);
    end
  endtask

  task automatic test_priority();
    acc(1, 1, 32'hFF);
    src = 8'h24; cyc(); src = 0; cyc(SS + 2);
    checks++;
    if (irq !== 1 || irq_id !== 2) begin
      errors++; $display("FAIL prio_2: got irq=%b id=%0d, want 1 2", irq, irq_id);
    end
    acc(3, 0, 0); cyc();
    checks++;
    if (q !== 32'h8000_0002) begin
      errors++; $display("FAIL vector_read: got %h, want 80000002", q);
    end
    acc(0, 1, 32'h04); cyc();
    checks++;
    if (irq !== 1 || irq_id !== 5) begin
      errors++; $display("FAIL prio_5: got irq=%b id=%0d, want 1 5", irq, irq_id);
    end
    acc(0, 1, 32'h20); cyc();
    checks++;
    if (irq !== 0 || irq_id !== 0) begin
      errors++; $display("FAIL prio_none: got irq=%b id=%0d, want 0 0", irq, irq_id);
    end
  endtask

  task automatic test_level();
    acc(2, 1, 32'hFE);
    src = 8'h01; cyc(SS + 3);
    acc(0, 1, 32'h01);
    acc(0, 0, 0); cyc();
    checks++;
    if (q !== 32'h01) begin
      errors++; $display("FAIL level_repend: got %h, want 00000001", q);
    end
    acc(4, 0, 0); cyc();
    checks++;
    if (q !== 32'h01) begin
      errors++; $display("FAIL raw_read: got %h, want 00000001", q);
    end
    src = 0; cyc(SS + 3);
    acc(0, 1, 32'h01);
    acc(0, 0, 0); cyc();
    checks++;
    if (q !== 0 || irq !== 0) begin
      errors++; $display("FAIL level_drop: got q=%h irq=%b, want 0 0", q, irq);
    end
    acc(2, 1, 32'hFF);
  endtask

  task automatic test_mask();
    acc(1, 1, 0);
    src = 8'h08; cyc(); src = 0; cyc(SS + 3);
    checks++;
    if (irq !== 0) begin
      errors++; $display("FAIL mask_irq: got %b, want 0", irq);
    end
    acc(0, 0, 0); cyc();
    checks++;
    if (q !== 32'h08) begin
      errors++; $display("FAIL mask_pending: got %h, want 00000008", q);
    end
    acc(1, 1, 32'h08);
    checks++;
    if (irq !== 0) begin
      errors++; $display("FAIL enable_commit: got irq=%b, want 0", irq);
    end
    cyc();
    checks++;
    if (irq !== 1 || irq_id !== 3) begin
      errors++; $display("FAIL enable_irq: got irq=%b id=%0d, want 1 3", irq, irq_id);
    end
    acc(0, 1, 32'h08);
    acc(1, 1, 32'hFF);
  endtask

  task automatic test_set_wins();
    src = 8'h02; cyc(); src = 0; cyc(SS - 1);
    acc(0, 1, 32'h02);
    acc(0, 0, 0); cyc();
    checks++;
    if (q !== 32'h02) begin
      errors++; $display("FAIL set_wins: got %h, want 00000002", q);
    end
    acc(0, 1, 32'h02); cyc(2);
  endtask

  task automatic test_reset_held_src();
    src = 8'h10; cyc(SS + 3);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if ({irq, irq_id, done, q} !== 0) begin
        errors++; $display("FAIL in_reset %0d: got irq=%b id=%0d done=%b q=%h, want all 0", i, irq, irq_id, done, q);
      end
    end
    reset = 0;
    acc(1, 1, 32'hFF); cyc(SS + 3);
    acc(0, 0, 0); cyc();
    checks++;
    if (q !== 32'h10 || irq !== 1 || irq_id !== 4) begin
      errors++; $display("FAIL held_one_edge: got q=%h irq=%b id=%0d, want 00000010 1 4", q, irq, irq_id);
    end
    acc(0, 1, 32'h10); cyc(SS + 3);
    acc(0, 0, 0); cyc();
    checks++;
    if (q !== 0 || irq !== 0) begin
      errors++; $display("FAIL held_no_repeat: got q=%h irq=%b, want 0 0", q, irq);
    end
    src = 0;
    for (int a = 5; a < 8; a++) begin
      acc(3'(a), 1, 32'hFFFF_FFFF);
      acc(3'(a), 0, 0);
      checks++;
      if (done !== 1 || q !== 0) begin
        errors++; $display("FAIL addr%0d_write: got done=%b q=%h, want 1 0", a, done, q);
      end
      cyc();
      checks++;
      if (done !== 1 || q !== 0) begin
        errors++; $display("FAIL addr%0d_read: got done=%b q=%h, want 1 0", a, done, q);
      end
      cyc();
      checks++;
      if (done !== 0) begin
        errors++; $display("FAIL addr%0d_done_pulse: got done=%b, want 0", a, done);
      end
    end
    acc(1, 0, 0); cyc();
    checks++;
    if (q !== 32'hFF) begin
      errors++; $display("FAIL enable_intact: got %h, want 000000ff", q);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      checks++;
      if (irq !== m_irq || irq_id !== m_id || done !== m_done || q !== m_q) begin
        errors++;
        $display("FAIL random cycle %0d: got irq=%b id=%0d done=%b q=%h, want irq=%b id=%0d done=%b q=%h",
                 n, irq, irq_id, done, q, m_irq, m_id, m_done, m_q);
      end
      src = 8'($urandom) & 8'($urandom);
      start = $urandom_range(0, 1) == 1;
      addr = 3'($urandom_range(0, 7));
      we = $urandom_range(0, 2) == 0;
      data = $urandom;
      reset = $urandom_range(0, 199) == 0;
      cyc();
    end
    start = 0; we = 0; reset = 0; src = 0;
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_priority();
    test_level();
    test_mask();
    test_set_wins();
    test_reset_held_src();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
